expr_token_buffer: RTL and testbench
====================================

Name: expr_token_buffer

Overview:
- Consumes the keyboard encoder's one-cycle pulse protocol: dataIn with insert, del_pulse, ptrLeft_pulse, ptrRight_pulse and eval_pulse.
- Holds the typed expression as an editable token array with a cursor.
- On eval, streams the stored tokens, in order, to the downstream evaluator over a valid/ready handshake.
- Sits between keyboard and evaluator; also gives the display a random-access read port.

Parameters:
- width, 8, token width in bits; matches the keyboard dataIn width.
- DEPTH, 32, maximum tokens stored.
- PW, $clog2(DEPTH+1), width of length and cursor fields (derived; do not override).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dataIn  in  width  token code; sampled only when insert=1.
- insert  in  1  one-cycle pulse: insert dataIn at the cursor.
- del_pulse  in  1  one-cycle pulse: backspace (remove the token left of the cursor).
- ptrLeft_pulse  in  1  one-cycle pulse: cursor left.
- ptrRight_pulse  in  1  one-cycle pulse: cursor right.
- eval_pulse  in  1  one-cycle pulse: start readout.
- tok_data  out  width  streamed token.
- tok_valid  out  1  tok_data is valid.
- tok_last  out  1  final token of the stream; qualified by tok_valid.
- tok_ready  in  1  downstream accepts the token.
- busy  out  1  readout in progress.
- len  out  PW  number of stored tokens, 0..DEPTH.
- cursor  out  PW  insertion point, 0..len.
- full  out  1  len==DEPTH.
- overflow  out  1  one-cycle pulse: insert rejected because the buffer was full.
- rd_addr  in  PW  display read index.
- rd_data  out  width  mem[rd_addr] one cycle after rd_addr; 0 if rd_addr>=len.

Behaviour:
- Reset (asynchronous): mem all 0, len=0, cursor=0, state=IDLE. tok_data=0, tok_valid=0, tok_last=0, busy=0, overflow=0, rd_data=0. Asserting reset mid-stream aborts the stream immediately; no partial completion.
- Edit command priority, at most one per cycle: insert > del > ptrLeft > ptrRight > eval. Lower-priority pulses in the same cycle are dropped; they are not queued.
- Edit commands act only in IDLE. In STREAM all edit pulses, including eval, are ignored.
- All edits complete in one cycle. Updated len, cursor and mem are visible the cycle after the pulse.
- insert, len<DEPTH:
  - mem[i+1]<=mem[i] for cursor<=i<len.
  - mem[cursor]<=dataIn.
  - cursor+=1, len+=1.
- insert, len==DEPTH: no state change; overflow=1 for one cycle.
- del, cursor>0:
  - mem[i-1]<=mem[i] for cursor<=i<len.
  - mem[len-1]<=0.
  - cursor-=1, len-=1.
- del, cursor==0: no-op. This applies even when len>0.
- ptrLeft: cursor-=1 if cursor>0, else no-op (no wrap).
- ptrRight: cursor+=1 if cursor<len, else no-op (no wrap).
- eval with len==0: ignored.
- eval with len>0: IDLE->STREAM; idx=0. Next cycle: tok_valid=1, tok_data=mem[0], tok_last=(len==1), busy=1.
- STREAM handshake:
  - Transfer occurs on a cycle with tok_valid&&tok_ready.
  - While tok_valid=1 and tok_ready=0, tok_data and tok_last are held stable.
  - On a transfer of a non-last token: idx+=1 and tok_data=mem[idx+1] next cycle. Back-to-back transfers give one token per cycle.
  - On the transfer with tok_last=1: STREAM->IDLE. Next cycle tok_valid=0, tok_last=0, busy=0.
  - Buffer contents, len and cursor are preserved after the stream.
- States: IDLE, STREAM. No other states.
- Arithmetic: len and cursor are unsigned PW bits. Guards above prevent underflow and overflow. The invariant cursor<=len holds at all times.
- rd_data is registered and returns 0 for an out-of-range index. It reflects mem after any edit in the same cycle, with one-cycle latency.

Decomposition:
- Shared package calc_pkg:
  - Token localparams OP_ADD=8'hA0, OP_SUB=8'hA1, OP_MUL=8'hA2, OP_DIV=8'hA3, OP_LB=8'hA4, OP_RB=8'hA5; digits 0-9 map to 8'h00-8'h09.
  - Default token width 8.
  - State encoding for IDLE/STREAM.
- One sub-module, token_shift_array, holds the DEPTH x width storage. Its operations are shift-right-insert at index, shift-left-delete at index, and combinational read.
- The top level owns cursor, len, priority arbitration and the stream FSM.

Test Plan:
- Insert 1, OP_ADD, 2 -> len=3, cursor=3, mem=[01,A0,02]. Eval with tok_ready=1 -> tokens 01,A0,02 on three consecutive cycles, tok_last on 02, busy falls the cycle after.
- From [01,A0,02] cursor=3: ptrLeft x2, then insert 07 -> mem=[01,07,A0,02], cursor=2. Del -> mem=[01,A0,02], cursor=1. Del at cursor=0 -> no change.
- Fill 32 tokens, then insert 05 -> overflow pulses one cycle, len stays 32, full=1. ptrRight at cursor=len -> cursor unchanged.
- Eval on 3 tokens with tok_ready low for 4 cycles after the first valid -> tok_data=01 held and stable; insert pulsed mid-stream is ignored (len stays 3).
- Same-cycle insert=1 and del_pulse=1 -> only the insert takes effect. Eval with len=0 -> tok_valid stays 0.
- Assert reset in the middle of a stream -> tok_valid, busy, len and cursor all go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: token codes, default
// token width and the encodings used by the expression token buffer.
package calc_pkg;

  localparam int TOKEN_W = 8;

  // Operator and bracket token codes; digits 0-9 encode as 8'h00-8'h09.
  localparam logic [TOKEN_W-1:0] OP_ADD = 8'hA0;
  localparam logic [TOKEN_W-1:0] OP_SUB = 8'hA1;
  localparam logic [TOKEN_W-1:0] OP_MUL = 8'hA2;
  localparam logic [TOKEN_W-1:0] OP_DIV = 8'hA3;
  localparam logic [TOKEN_W-1:0] OP_LB  = 8'hA4;
  localparam logic [TOKEN_W-1:0] OP_RB  = 8'hA5;

  // Readout FSM: editing happens in IDLE, the token stream in STREAM.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Operation requested from the token storage in a given cycle.
  typedef enum logic [1:0] {
    ARR_NONE   = 2'd0,
    ARR_INSERT = 2'd1,
    ARR_DELETE = 2'd2
  } arr_op_e;

  // Token code for a decimal digit 0..9.
  function automatic logic [TOKEN_W-1:0] digit_token(input logic [3:0] d);
    return {{(TOKEN_W-4){1'b0}}, d};
  endfunction

endpackage

// File: rtl/token_shift_array.sv
// DEPTH x WIDTH token storage supporting shift-right insert and
// shift-left delete at an index, plus two combinational read ports:
// one on the current contents, one on the contents after this cycle's edit.
module token_shift_array
  import calc_pkg::*;
#(
  parameter int WIDTH = TOKEN_W,
  parameter int DEPTH = 32,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  arr_op_e          op_i,
  input  logic [PW-1:0]    pos_i,
  input  logic [PW-1:0]    len_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [PW-1:0]    rd_cur_addr_i,
  output logic [WIDTH-1:0] rd_cur_data_o,
  input  logic [PW-1:0]    rd_nxt_addr_i,
  output logic [WIDTH-1:0] rd_nxt_data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next-state contents: shift the tail right on insert, left on delete.
  always_comb begin
    // NOTE: start from the held value so every element is assigned on every
    // path; a missing default here would infer a latch per token.
    mem_d = mem_q;
    case (op_i)
      ARR_INSERT: begin
        for (int i = 1; i < DEPTH; i++) begin
          if (PW'(i) > pos_i && PW'(i) <= len_i) mem_d[i] = mem_q[i-1];
        end
        mem_d[AW'(pos_i)] = din_i;
      end
      ARR_DELETE: begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (PW'(i) >= pos_i && PW'(i) < len_i - PW'(1)) mem_d[i] = mem_q[i+1];
        end
        mem_d[AW'(len_i - PW'(1))] = '0;
      end
      default: ;
    endcase
  end

  // Storage register; cleared on reset so unused slots always read as 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: this storage is reset on purpose: the buffer must power up
      // empty with all-zero slots, so it cannot map to an unreset RAM.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignment so every element updates from the
      // pre-edge values, which the shift relies on.
      mem_q <= mem_d;
    end
  end

  assign rd_cur_data_o = mem_q[AW'(rd_cur_addr_i)];
  assign rd_nxt_data_o = mem_d[AW'(rd_nxt_addr_i)];

endmodule

// File: rtl/expr_token_buffer.sv
// Editable expression token buffer with a cursor. Accepts keyboard edit
// pulses in IDLE and, on eval, streams the tokens to the evaluator over a
// valid/ready handshake. Also serves a registered display read port.
module expr_token_buffer
  import calc_pkg::*;
#(
  parameter  int width = TOKEN_W,
  parameter  int DEPTH = 32,
  localparam int PW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] dataIn,
  input  logic             insert,
  input  logic             del_pulse,
  input  logic             ptrLeft_pulse,
  input  logic             ptrRight_pulse,
  input  logic             eval_pulse,
  output logic [width-1:0] tok_data,
  output logic             tok_valid,
  output logic             tok_last,
  input  logic             tok_ready,
  output logic             busy,
  output logic [PW-1:0]    len,
  output logic [PW-1:0]    cursor,
  output logic             full,
  output logic             overflow,
  input  logic [PW-1:0]    rd_addr,
  output logic [width-1:0] rd_data
);

  state_e           state_q, state_d;
  logic [PW-1:0]    len_q, len_d;
  logic [PW-1:0]    cursor_q, cursor_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic [width-1:0] tok_data_q, tok_data_d;
  logic             tok_valid_q, tok_valid_d;
  logic             tok_last_q, tok_last_d;
  logic             overflow_q, overflow_d;
  logic [width-1:0] rd_data_q, rd_data_d;

  arr_op_e          arr_op;
  logic [PW-1:0]    arr_pos;
  logic [PW-1:0]    stream_addr;
  logic [width-1:0] stream_tok;
  logic [width-1:0] rd_nxt_tok;

  // In IDLE the stream read port points at token 0, ready for eval;
  // in STREAM it points one past the token currently presented.
  assign stream_addr = (state_q == ST_IDLE) ? '0 : idx_q + PW'(1);

  token_shift_array #(
    .WIDTH(width),
    .DEPTH(DEPTH),
    .PW   (PW)
  ) u_array (
    .clock        (clock),
    .reset        (reset),
    .op_i         (arr_op),
    .pos_i        (arr_pos),
    .len_i        (len_q),
    .din_i        (dataIn),
    .rd_cur_addr_i(stream_addr),
    .rd_cur_data_o(stream_tok),
    .rd_nxt_addr_i(rd_addr),
    .rd_nxt_data_o(rd_nxt_tok)
  );

  // Edit arbitration (insert > del > left > right > eval) and stream FSM.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cursor_d    = cursor_q;
    idx_d       = idx_q;
    tok_data_d  = tok_data_q;
    tok_valid_d = tok_valid_q;
    tok_last_d  = tok_last_q;
    overflow_d  = 1'b0;
    arr_op      = ARR_NONE;
    arr_pos     = cursor_q;

    case (state_q)
      ST_IDLE: begin
        if (insert) begin
          if (len_q != PW'(DEPTH)) begin
            arr_op   = ARR_INSERT;
            cursor_d = cursor_q + PW'(1);
            len_d    = len_q + PW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end else if (del_pulse) begin
          if (cursor_q != '0) begin
            arr_op   = ARR_DELETE;
            arr_pos  = cursor_q - PW'(1);
            cursor_d = cursor_q - PW'(1);
            len_d    = len_q - PW'(1);
          end
        end else if (ptrLeft_pulse) begin
          if (cursor_q != '0) cursor_d = cursor_q - PW'(1);
        end else if (ptrRight_pulse) begin
          if (cursor_q < len_q) cursor_d = cursor_q + PW'(1);
        end else if (eval_pulse && len_q != '0) begin
          state_d     = ST_STREAM;
          idx_d       = '0;
          tok_data_d  = stream_tok;
          tok_valid_d = 1'b1;
          tok_last_d  = (len_q == PW'(1));
        end
      end
      ST_STREAM: begin
        if (tok_valid_q && tok_ready) begin
          if (tok_last_q) begin
            state_d     = ST_IDLE;
            tok_data_d  = '0;
            tok_valid_d = 1'b0;
            tok_last_d  = 1'b0;
          end else begin
            idx_d      = idx_q + PW'(1);
            tok_data_d = stream_tok;
            tok_last_d = (idx_q + PW'(2) == len_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_data_d = (rd_addr < len_d) ? rd_nxt_tok : '0;
  end

  // Control and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cursor_q    <= '0;
      idx_q       <= '0;
      tok_data_q  <= '0;
      tok_valid_q <= 1'b0;
      tok_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cursor_q    <= cursor_d;
      idx_q       <= idx_d;
      tok_data_q  <= tok_data_d;
      tok_valid_q <= tok_valid_d;
      tok_last_q  <= tok_last_d;
      overflow_q  <= overflow_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign tok_data  = tok_data_q;
  assign tok_valid = tok_valid_q;
  assign tok_last  = tok_last_q;
  assign busy      = (state_q == ST_STREAM);
  assign len       = len_q;
  assign cursor    = cursor_q;
  assign full      = (len_q == PW'(DEPTH));
  assign overflow  = overflow_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_expr_token_buffer.sv
// Directed self-checking bench for expr_token_buffer. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_expr_token_buffer;
  import calc_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 32;
  localparam int PW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  dataIn = '0;
  logic          insert = 1'b0, del_pulse = 1'b0, ptrLeft_pulse = 1'b0;
  logic          ptrRight_pulse = 1'b0, eval_pulse = 1'b0;
  logic [W-1:0]  tok_data;
  logic          tok_valid, tok_last, tok_ready = 1'b1;
  logic          busy, full, overflow;
  logic [PW-1:0] len, cursor, rd_addr = '0;
  logic [W-1:0]  rd_data;

  int checks   = 0;
  int failures = 0;

  expr_token_buffer #(.width(W), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .dataIn        (dataIn),
    .insert        (insert),
    .del_pulse     (del_pulse),
    .ptrLeft_pulse (ptrLeft_pulse),
    .ptrRight_pulse(ptrRight_pulse),
    .eval_pulse    (eval_pulse),
    .tok_data      (tok_data),
    .tok_valid     (tok_valid),
    .tok_last      (tok_last),
    .tok_ready     (tok_ready),
    .busy          (busy),
    .len           (len),
    .cursor        (cursor),
    .full          (full),
    .overflow      (overflow),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  always #5 clock = ~clock;

  // Apply reset for two cycles; returns just after a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    tok_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Drive one cycle of command pulses; state is observable on return.
  task automatic cmd(input logic ins, input logic dl, input logic lf,
                     input logic rt, input logic ev, input logic [W-1:0] d);
    insert = ins; del_pulse = dl; ptrLeft_pulse = lf;
    ptrRight_pulse = rt; eval_pulse = ev; dataIn = d;
    @(negedge clock);
    insert = 1'b0; del_pulse = 1'b0; ptrLeft_pulse = 1'b0;
    ptrRight_pulse = 1'b0; eval_pulse = 1'b0; dataIn = '0;
  endtask

  task automatic read_mem(input logic [PW-1:0] a, output logic [W-1:0] d);
    rd_addr = a;
    @(negedge clock);
    d = rd_data;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({len, cursor} !== {PW'(0), PW'(0)}) begin
      failures++; $display("FAIL reset_len_cursor: got len=%0d cursor=%0d, want 0 0", len, cursor);
    end
    checks++;
    if ({tok_valid, tok_last, busy, full, overflow} !== 5'b0 || tok_data !== '0 || rd_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b l=%b busy=%b full=%b ovf=%b data=%h rd=%h, want all 0",
               tok_valid, tok_last, busy, full, overflow, tok_data, rd_data);
    end
  endtask

  task automatic test_insert_eval();
    logic [W-1:0] exp_tok [3];
    logic [W-1:0] got;
    exp_tok[0] = 8'h01; exp_tok[1] = OP_ADD; exp_tok[2] = 8'h02;
    do_reset();
    for (int i = 0; i < 3; i++) cmd(1, 0, 0, 0, 0, exp_tok[i]);
    checks++;
    if (len !== PW'(3) || cursor !== PW'(3)) begin
      failures++; $display("FAIL insert_len_cursor: got len=%0d cursor=%0d, want 3 3", len, cursor);
    end
    for (int i = 0; i < 4; i++) begin
      read_mem(PW'(i), got);
      checks++;
      if (got !== ((i < 3) ? exp_tok[i] : 8'h00)) begin
        failures++; $display("FAIL insert_mem[%0d]: got %h, want %h", i, got, (i < 3) ? exp_tok[i] : 8'h00);
      end
    end
    tok_ready = 1'b1;
    cmd(0, 0, 0, 0, 1, '0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tok_valid !== 1'b1 || busy !== 1'b1 || tok_data !== exp_tok[i] || tok_last !== (i == 2)) begin
        failures++;
        $display("FAIL stream_tok%0d: got v=%b busy=%b data=%h last=%b, want 1 1 %h %b",
                 i, tok_valid, busy, tok_data, tok_last, exp_tok[i], i == 2);
      end
      @(negedge clock);
    end
    checks++;
    if (tok_valid !== 1'b0 || busy !== 1'b0 || tok_last !== 1'b0 || len !== PW'(3) || cursor !== PW'(3)) begin
      failures++;
      $display("FAIL stream_end: got v=%b busy=%b last=%b len=%0d cursor=%0d, want 0 0 0 3 3",
               tok_valid, busy, tok_last, len, cursor);
    end
  endtask

  // Runs from the [01,A0,02] cursor=3 state left by test_insert_eval.
  task automatic test_edit();
    logic [W-1:0] exp_a [4];
    logic [W-1:0] got;
    exp_a[0] = 8'h01; exp_a[1] = 8'h07; exp_a[2] = OP_ADD; exp_a[3] = 8'h02;
    cmd(0, 0, 1, 0, 0, '0);
    cmd(0, 0, 1, 0, 0, '0);
    checks++;
    if (cursor !== PW'(1)) begin
      failures++; $display("FAIL ptr_left: got cursor=%0d, want 1", cursor);
    end
    cmd(1, 0, 0, 0, 0, 8'h07);
    checks++;
    if (len !== PW'(4) || cursor !== PW'(2)) begin
      failures++; $display("FAIL mid_insert: got len=%0d cursor=%0d, want 4 2", len, cursor);
    end
    for (int i = 0; i < 4; i++) begin
      read_mem(PW'(i), got);
      checks++;
      if (got !== exp_a[i]) begin
        failures++; $display("FAIL mid_insert_mem[%0d]: got %h, want %h", i, got, exp_a[i]);
      end
    end
    cmd(0, 1, 0, 0, 0, '0);
    checks++;
    if (len !== PW'(3) || cursor !== PW'(1)) begin
      failures++; $display("FAIL del: got len=%0d cursor=%0d, want 3 1", len, cursor);
    end
    for (int i = 0; i < 4; i++) begin
      read_mem(PW'(i), got);
      checks++;
      if (got !== ((i == 0) ? 8'h01 : (i == 1) ? OP_ADD : (i == 2) ? 8'h02 : 8'h00)) begin
        failures++; $display("FAIL del_mem[%0d]: got %h", i, got);
      end
    end
    cmd(0, 0, 1, 0, 0, '0);
    cmd(0, 1, 0, 0, 0, '0);
    read_mem(PW'(0), got);
    checks++;
    if (len !== PW'(3) || cursor !== PW'(0) || got !== 8'h01) begin
      failures++; $display("FAIL del_at_zero: got len=%0d cursor=%0d mem0=%h, want 3 0 01", len, cursor, got);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] got;
    do_reset();
    for (int i = 0; i < DEPTH; i++) cmd(1, 0, 0, 0, 0, W'(i + 16));
    checks++;
    if (len !== PW'(DEPTH) || full !== 1'b1 || cursor !== PW'(DEPTH) || overflow !== 1'b0) begin
      failures++; $display("FAIL fill: got len=%0d full=%b cursor=%0d ovf=%b, want 32 1 32 0", len, full, cursor, overflow);
    end
    cmd(1, 0, 0, 0, 0, 8'h05);
    checks++;
    if (overflow !== 1'b1 || len !== PW'(DEPTH)) begin
      failures++; $display("FAIL overflow_pulse: got ovf=%b len=%0d, want 1 32", overflow, len);
    end
    @(negedge clock);
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL overflow_one_cycle: got ovf=%b, want 0", overflow);
    end
    cmd(0, 0, 0, 1, 0, '0);
    checks++;
    if (cursor !== PW'(DEPTH)) begin
      failures++; $display("FAIL ptr_right_clamp: got cursor=%0d, want 32", cursor);
    end
    read_mem(PW'(DEPTH - 1), got);
    checks++;
    if (got !== 8'h2F) begin
      failures++; $display("FAIL full_last_mem: got %h, want 2f", got);
    end
  endtask

  task automatic test_stall();
    do_reset();
    cmd(1, 0, 0, 0, 0, 8'h01);
    cmd(1, 0, 0, 0, 0, OP_ADD);
    cmd(1, 0, 0, 0, 0, 8'h02);
    tok_ready = 1'b0;
    cmd(0, 0, 0, 0, 1, '0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (tok_valid !== 1'b1 || tok_data !== 8'h01 || tok_last !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL stall_hold%0d: got v=%b data=%h last=%b busy=%b, want 1 01 0 1",
                             c, tok_valid, tok_data, tok_last, busy);
      end
      if (c == 1) cmd(1, 0, 0, 0, 0, 8'h09);
      else @(negedge clock);
    end
    tok_ready = 1'b1;
    checks++;
    if (tok_data !== 8'h01 || len !== PW'(3)) begin
      failures++; $display("FAIL stall_ignore_insert: got data=%h len=%0d, want 01 3", tok_data, len);
    end
    @(negedge clock);
    checks++;
    if (tok_data !== OP_ADD || tok_valid !== 1'b1) begin
      failures++; $display("FAIL stall_resume: got data=%h v=%b, want a0 1", tok_data, tok_valid);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || len !== PW'(3)) begin
      failures++; $display("FAIL stall_end: got busy=%b len=%0d, want 0 3", busy, len);
    end
  endtask

  task automatic test_priority();
    logic [W-1:0] got;
    do_reset();
    cmd(0, 0, 0, 0, 1, '0);
    checks++;
    if (tok_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL eval_empty: got v=%b busy=%b, want 0 0", tok_valid, busy);
    end
    cmd(1, 1, 0, 0, 0, 8'h09);
    read_mem(PW'(0), got);
    checks++;
    if (len !== PW'(1) || cursor !== PW'(1) || got !== 8'h09) begin
      failures++; $display("FAIL ins_over_del: got len=%0d cursor=%0d mem0=%h, want 1 1 09", len, cursor, got);
    end
    cmd(0, 0, 1, 1, 0, '0);
    checks++;
    if (cursor !== PW'(0)) begin
      failures++; $display("FAIL left_over_right: got cursor=%0d, want 0", cursor);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) cmd(1, 0, 0, 0, 0, W'(i + 1));
    tok_ready = 1'b0;
    cmd(0, 0, 0, 0, 1, '0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tok_valid !== 1'b0 || busy !== 1'b0 || len !== PW'(0) || cursor !== PW'(0)) begin
      failures++; $display("FAIL async_reset: got v=%b busy=%b len=%0d cursor=%0d, want 0 0 0 0",
                           tok_valid, busy, len, cursor);
    end
    @(negedge clock);
    reset = 1'b0;
    tok_ready = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_insert_eval();
    test_edit();
    test_overflow();
    test_stall();
    test_priority();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
